sample_fifo: RTL and testbench

Parametrised sample FIFO for the sound subsystem, placed between the bus-side sample writer and the audio output engine. It stores DEPTH = 2^ADDR_WIDTH samples of DATA_WIDTH bits and returns one registered sample per accepted pop. It provides:
- full/empty protection and an exact occupancy count;
- a low-water request that tells the CPU/DMA to refill;
- sticky overflow/underflow error flags;
- synchronous flush.

---
 rtl/sound_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 65 ++++++
 rtl/sample_fifo.sv | 174 +++++++++++++++++
 tb/tb_sample_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// ============================================================================
// Module      : sound_pkg
// Description : Shared definitions for the sound subsystem. Holds the
//               default sample/FIFO widths and the sample data type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sound_pkg;

  // Default sample width in bits
  localparam int SAMPLE_WIDTH    = 8;
  // Default log2 of the sample FIFO depth
  localparam int FIFO_ADDR_WIDTH = 10;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage : sound_pkg

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port sample RAM, one write port and one
//               registered read port. The array has no reset so it maps
//               onto block RAM; only the output register is reset.
// Ports       : clk      - clock
//               reset    - asynchronous active-high reset (output reg only)
//               wr_en    - write strobe
//               wr_addr  - write address
//               wr_data  - write data
//               rd_en    - read enable, loads the output register
//               rd_addr  - read address
//               rd_data  - registered read data, holds when rd_en is low
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram
  import sound_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : fifo_ram

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// Module      : sample_fifo
// Description : Sample FIFO between the bus-side writer and the audio output
//               engine. DEPTH = 2^ADDR_WIDTH entries, exact occupancy count,
//               low-water refill request, sticky overflow/underflow flags
//               and synchronous flush.
// Config      : SAMPLE_FIFO_PEAK_EN - when defined, adds the peakLevel
//               output tracking the maximum level since reset/errClear.
// Ports       : clk, reset (async, active-high)
//               flush              - synchronous empty request
//               push, pushData     - write side
//               pop                - read request
//               popData, popValid  - registered read sample + 1-cycle pulse
//               full, empty, level - occupancy status
//               lowWater           - level < LOW_THRESHOLD
//               overflow/underflow - sticky error flags, errClear clears
//               peakLevel          - (SAMPLE_FIFO_PEAK_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo
  import sound_pkg::*;
#(
  parameter int DATA_WIDTH    = SAMPLE_WIDTH,
  parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
  parameter int LOW_THRESHOLD = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] popData,
  output logic                  popValid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  lowWater,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  errClear
`ifdef SAMPLE_FIFO_PEAK_EN
  ,
  output logic [ADDR_WIDTH:0]   peakLevel
`endif
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_LOW   = (ADDR_WIDTH+1)'(LOW_THRESHOLD);
  localparam logic [ADDR_WIDTH:0] LVL_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_WIDTH:0]   level_d, level_q;
  logic                  pop_valid_d, pop_valid_q;
  logic                  overflow_d, overflow_q;
  logic                  underflow_d, underflow_q;

  logic push_acc, pop_acc, push_rej, pop_rej;

  // Status decodes come straight from the registered level, so full/empty
  // reflect the start-of-cycle state and a same-cycle pop cannot make room
  // for a push (nor a push feed a pop).
  assign full     = (level_q == LVL_DEPTH);
  assign empty    = (level_q == '0);
  assign lowWater = (level_q < LVL_LOW);

  assign push_acc = push & ~full  & ~flush;
  assign pop_acc  = pop  & ~empty & ~flush;
  // Requests masked by flush are not errors
  assign push_rej = push & full  & ~flush;
  assign pop_rej  = pop  & empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pop_valid_d = pop_acc;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_acc && !pop_acc) begin
        level_d = level_q + LVL_ONE;
      end else if (pop_acc && !push_acc) begin
        level_d = level_q - LVL_ONE;
      end
    end
  end

  // A fresh error in the same cycle as errClear keeps the flag set
  always_comb begin
    overflow_d  = push_rej | (overflow_q  & ~errClear);
    underflow_d = pop_rej  | (underflow_q & ~errClear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign level     = level_q;
  assign popValid  = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // The RAM output register doubles as the popData register; it only loads
  // on an accepted pop, so it holds through idle and flush cycles.
  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (pushData),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (popData)
  );

`ifdef SAMPLE_FIFO_PEAK_EN
  logic [ADDR_WIDTH:0] peak_level_d, peak_level_q;

  // Compares against the registered level, so the peak lags level by one
  // cycle. errClear restarts tracking from the current level.
  always_comb begin
    peak_level_d = peak_level_q;
    if (errClear) begin
      peak_level_d = level_q;
    end else if (level_q > peak_level_q) begin
      peak_level_d = level_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_level_q <= '0;
    end else begin
      peak_level_q <= peak_level_d;
    end
  end

  assign peakLevel = peak_level_q;
`endif

endmodule : sample_fifo

`default_nettype wire

// File: tb/tb_sample_fifo.sv
// ============================================================================
// Module      : tb_sample_fifo
// Description : Self-checking bench for sample_fifo (default parameters).
//               Directed vector table plus hand-written multi-cycle
//               sequences. Peak checks are built when SAMPLE_FIFO_PEAK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_fifo;
  import sound_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  sample_t       pushData = '0;
  logic          pop = 1'b0;
  sample_t       popData;
  logic          popValid;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          lowWater;
  logic          overflow;
  logic          underflow;
  logic          errClear = 1'b0;
`ifdef SAMPLE_FIFO_PEAK_EN
  logic [AW:0]   peakLevel;
`endif

  int total = 0;
  int bad   = 0;

  sample_fifo #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (AW),
    .LOW_THRESHOLD (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pushData  (pushData),
    .pop       (pop),
    .popData   (popData),
    .popValid  (popValid),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .lowWater  (lowWater),
    .overflow  (overflow),
    .underflow (underflow),
    .errClear  (errClear)
`ifdef SAMPLE_FIFO_PEAK_EN
    ,
    .peakLevel (peakLevel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic    fl, pu;
    sample_t d;
    logic    po, ec;
    logic    pv;
    sample_t pd;
    int      lvl;
    logic    emp, ful, low, ovf, unf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge
  task automatic step(input logic fl, input logic pu, input sample_t d,
                      input logic po, input logic ec);
    flush = fl; push = pu; pushData = d; pop = po; errClear = ec;
    @(posedge clk);
    #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0; errClear = 1'b0;
  endtask

  task automatic chk_status(input string nm, input int lvl, input logic emp,
                            input logic ful, input logic low);
    chk({nm, ".level"},    int'(level),    lvl);
    chk({nm, ".empty"},    int'(empty),    int'(emp));
    chk({nm, ".full"},     int'(full),     int'(ful));
    chk({nm, ".lowWater"}, int'(lowWater), int'(low));
  endtask

  initial begin
    // fl pu  d     po ec | pv pd    lvl emp ful low ovf unf
    vecs[0]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    vecs[1]  = '{0, 1, 8'h11, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 1, 8'h22, 0, 0, 0, 8'h00, 2, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 1, 8'h33, 0, 0, 0, 8'h00, 3, 0, 0, 1, 0, 0};
    vecs[4]  = '{0, 0, 8'h00, 1, 0, 1, 8'h11, 2, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 8'h00, 1, 0, 1, 8'h22, 1, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 0, 8'h00, 1, 0, 1, 8'h33, 0, 1, 0, 1, 0, 0};
    vecs[7]  = '{0, 0, 8'h00, 0, 0, 0, 8'h33, 0, 1, 0, 1, 0, 0};
    // pop on empty with push: rejected pop, no write-through
    vecs[8]  = '{0, 1, 8'hA5, 1, 0, 0, 8'h33, 1, 0, 0, 1, 0, 1};
    vecs[9]  = '{0, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 1, 0, 1, 0, 1};
    // errClear with concurrent rejected pop: flag stays set
    vecs[10] = '{0, 0, 8'h00, 1, 1, 0, 8'hA5, 0, 1, 0, 1, 0, 1};
    vecs[11] = '{0, 0, 8'h00, 0, 1, 0, 8'hA5, 0, 1, 0, 1, 0, 0};

    // ---------------- reset state ----------------
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst.popData",   int'(popData),   0);
    chk("rst.popValid",  int'(popValid),  0);
    chk("rst.overflow",  int'(overflow),  0);
    chk("rst.underflow", int'(underflow), 0);
    chk_status("rst", 0, 1'b1, 1'b0, 1'b1);
`ifdef SAMPLE_FIFO_PEAK_EN
    chk("rst.peakLevel", int'(peakLevel), 0);
`endif

    // ---------------- vector table ----------------
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].fl, vecs[i].pu, vecs[i].d, vecs[i].po, vecs[i].ec);
      chk($sformatf("vec%0d.popValid", i), int'(popValid), int'(vecs[i].pv));
      chk($sformatf("vec%0d.popData", i),  int'(popData),  int'(vecs[i].pd));
      chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].ovf));
      chk($sformatf("vec%0d.underflow", i), int'(underflow), int'(vecs[i].unf));
      chk_status($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].emp,
                 vecs[i].ful, vecs[i].low);
    end

    // ---------------- steady push+pop at level 5 ----------------
    for (int i = 0; i < 5; i++) step(0, 1, sample_t'(8'h50 + i), 0, 0);
    chk_status("lvl5", 5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, sample_t'(8'h55 + i), 1, 0);
      chk($sformatf("steady%0d.level", i),   int'(level),    5);
      chk($sformatf("steady%0d.popValid", i), int'(popValid), 1);
      chk($sformatf("steady%0d.popData", i), int'(popData),  8'h50 + i);
    end
    // flush with push and pop asserted
    step(1, 1, 8'hEE, 1, 0);
    chk_status("flush", 0, 1'b1, 1'b0, 1'b1);
    chk("flush.popValid",  int'(popValid),  0);
    chk("flush.popData",   int'(popData),   8'h59);
    chk("flush.overflow",  int'(overflow),  0);
    chk("flush.underflow", int'(underflow), 0);

    // ---------------- fill / overflow / drain with wrap ----------------
    // Offset the pointers so the fill wraps the RAM address
    for (int i = 0; i < 3; i++) step(0, 1, 8'h77, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
    chk_status("offset", 0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 1024; i++) begin
      step(0, 1, sample_t'(i), 0, 0);
      if (i == 254) chk_status("low255", 255, 1'b0, 1'b0, 1'b1);
      if (i == 255) chk_status("low256", 256, 1'b0, 1'b0, 1'b0);
    end
    chk_status("filled", 1024, 1'b0, 1'b1, 1'b0);
    chk("filled.overflow", int'(overflow), 0);
    step(0, 1, 8'hFF, 0, 0);
    chk_status("push1025", 1024, 1'b0, 1'b1, 1'b0);
    chk("push1025.overflow", int'(overflow), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("errclr.overflow", int'(overflow), 0);
    // push while full is rejected even with an accepted pop
    step(0, 1, 8'hFF, 1, 0);
    chk("fullpp.overflow", int'(overflow), 1);
    chk("fullpp.popData",  int'(popData),  0);
    chk_status("fullpp", 1023, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 1024; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk($sformatf("drain%0d.popData", i), int'(popData), i & 8'hFF);
      chk($sformatf("drain%0d.popValid", i), int'(popValid), 1);
    end
    chk_status("drained", 0, 1'b1, 1'b0, 1'b1);

`ifdef SAMPLE_FIFO_PEAK_EN
    // ---------------- peak tracking ----------------
    chk("peak.afterfill", int'(peakLevel), 1024);
    step(0, 0, 8'h00, 0, 1);
    chk("peak.cleared", int'(peakLevel), 0);
    for (int i = 0; i < 40; i++) step(0, 1, sample_t'(i), 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, sample_t'(i), 0, 0);
    chk("peak.level20", int'(level), 20);
    chk("peak.40", int'(peakLevel), 40);
    step(0, 0, 8'h00, 0, 1);
    chk("peak.clr20", int'(peakLevel), 20);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("peak.21", int'(peakLevel), 21);
    step(1, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("peak.flushkeep", int'(peakLevel), 21);
`endif

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 4; i++) step(0, 1, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 1'b0);
    pop = 1'b1;
    step(0, 0, 8'h00, 1, 0);  // underflow-free pops; now make an error
    for (int i = 0; i < 2; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);  // pop on empty -> underflow
    chk("prerst.underflow", int'(underflow), 1);
    step(0, 1, 8'h3C, 0, 0);
    reset = 1'b1;
    #1;
    chk("arst.popData",   int'(popData),   0);
    chk("arst.underflow", int'(underflow), 0);
    chk("arst.popValid",  int'(popValid),  0);
    chk_status("arst", 0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sample_fifo

`default_nettype wire
